// File: rtl/rssb_core_if.sv
// Bus between rssb_core and its surroundings: start request, the ROM port,
// the output result port and the debug view of pc/acc/status.
interface rssb_core_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] address;
    logic [WIDTH-1:0] out_rom;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             busy;
    logic             halted;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] acc;

    modport master (
        output start, out_rom,
        input  address, out_data, out_valid, busy, halted, pc, acc
    );

    modport slave (
        input  start, out_rom,
        output address, out_data, out_valid, busy, halted, pc, acc
    );
endinterface

// File: rtl/rssb_core.sv
// RSSB one-instruction processor: copies the ROM image into a private RAM on
// start, then runs reverse-subtract-and-skip-if-borrow until a halt word.
module rssb_core #(
    parameter int WIDTH     = 8,
    parameter int IMAGE_LEN = 16,
    parameter int OUT_ADDR  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    rssb_core_if.slave bus
);
    localparam int DEPTH = 2 ** WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(IMAGE_LEN - 1);
    localparam logic [WIDTH-1:0] OUT_A     = WIDTH'(OUT_ADDR);
    localparam logic [WIDTH-1:0] HALT_WORD = '1;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_address;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_ir;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_halted;
    logic [WIDTH-1:0] r_ram [DEPTH];

    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_m;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_pc_step;

    // Reads are asynchronous, so EXEC sees the pre-write value even when the
    // operand points at the instruction itself.
    assign w_word    = r_ram[r_pc];
    assign w_m       = r_ram[r_ir];
    assign w_diff    = w_m - r_acc;
    assign w_borrow  = (w_m < r_acc);
    assign w_pc_step = w_borrow ? TWO : ONE;

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            r_ram[r_address] <= bus.out_rom;
        end else if (r_state == S_EXEC) begin
            r_ram[r_ir] <= w_diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_address   <= '0;
            r_pc        <= '0;
            r_acc       <= '0;
            r_ir        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_state   <= S_LOAD;
                        r_address <= '0;
                        r_pc      <= '0;
                        r_acc     <= '0;
                        r_busy    <= 1'b1;
                        r_halted  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (r_address == LAST_ADDR) begin
                        r_state   <= S_FETCH;
                        r_address <= '0;
                    end else begin
                        r_address <= r_address + ONE;
                    end
                end
                S_FETCH: begin
                    r_ir <= w_word;
                    if (w_word == HALT_WORD) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_acc   <= w_diff;
                    r_pc    <= r_pc + w_pc_step;
                    r_state <= S_FETCH;
                    if (r_ir == OUT_A) begin
                        r_out_data  <= w_diff;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.address   = r_address;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.halted    = r_halted;
    assign bus.pc        = r_pc;
    assign bus.acc       = r_acc;
endmodule

// File: tb/tb_rssb_core.sv
// Scoreboard bench for rssb_core: a 16-word-image core for load, arithmetic,
// output and random programs, and a full 256-word-image core for pc wrap-around.
module tb_rssb_core;
    localparam int W     = 8;
    localparam int OUT_A = 15;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic [7:0]  pc;
        logic [7:0]  acc;
        logic        dut;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rssb_core_if #(.WIDTH(W)) busA ();
    rssb_core_if #(.WIDTH(W)) busB ();

    rssb_core #(.WIDTH(W), .IMAGE_LEN(16), .OUT_ADDR(OUT_A)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA)
    );
    rssb_core #(.WIDTH(W), .IMAGE_LEN(256), .OUT_ADDR(OUT_A)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB)
    );

    logic       startS    [2];
    logic [7:0] romA      [256];
    logic [7:0] romB      [256];
    logic [7:0] addrS     [2];
    logic [7:0] pcS       [2];
    logic [7:0] accS      [2];
    logic [7:0] outDataS  [2];
    logic       outValidS [2];
    logic       busyS     [2];
    logic       haltedS   [2];

    assign busA.start   = startS[0];
    assign busB.start   = startS[1];
    assign busA.out_rom = romA[busA.address];
    assign busB.out_rom = romB[busB.address];
    assign addrS[0] = busA.address;    assign addrS[1] = busB.address;
    assign pcS[0] = busA.pc;           assign pcS[1] = busB.pc;
    assign accS[0] = busA.acc;         assign accS[1] = busB.acc;
    assign outDataS[0] = busA.out_data;    assign outDataS[1] = busB.out_data;
    assign outValidS[0] = busA.out_valid;  assign outValidS[1] = busB.out_valid;
    assign busyS[0] = busA.busy;       assign busyS[1] = busB.busy;
    assign haltedS[0] = busA.halted;   assign haltedS[1] = busB.halted;

    int          nVec = 0;
    int          nErr = 0;
    int unsigned cyc  = 0;
    exp_t        outQ  [$];
    exp_t        haltQ [$];
    logic        prevHalted [2] = '{1'b0, 1'b0};

    logic [7:0] mOutData [$];
    int         mOutStep [$];
    int         mPc, mAcc, mSteps;
    bit         mHalted;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVec++;
        if (actual != expected) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Plain-integer RSSB interpreter over a copy of the image; returns 0 if the
    // program touches words outside the loaded image (their contents are undefined).
    function automatic bit runModel(input int d, input int maxSteps);
        int ram [256];
        int len, pc, acc, opnd, m;
        bit borrow;
        len = (d == 0) ? 16 : 256;
        for (int i = 0; i < 256; i++) ram[i] = (d == 0) ? int'(romA[i]) : int'(romB[i]);
        pc = 0; acc = 0; mHalted = 1'b0; mSteps = 0;
        mOutData.delete(); mOutStep.delete();
        while (mSteps < maxSteps) begin
            if (pc >= len) return 1'b0;
            if (ram[pc] == 255) begin
                mHalted = 1'b1;
                break;
            end
            opnd = ram[pc];
            if (opnd >= len) return 1'b0;
            m      = ram[opnd];
            borrow = (m < acc);
            acc    = (m - acc + 256) % 256;
            ram[opnd] = acc;
            pc = (pc + (borrow ? 2 : 1)) % 256;
            if (opnd == OUT_A) begin
                mOutData.push_back(8'(acc));
                mOutStep.push_back(mSteps);
            end
            mSteps++;
        end
        mPc  = pc;
        mAcc = acc;
        return 1'b1;
    endfunction

    function automatic logic [7:0] randWord();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 8'hFF;
        if (r < 3) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(0, 15));
    endfunction

    // Monitor: pops the scoreboard whenever a core pulses out_valid or enters HALT.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && outValidS[d]) begin
                if (outQ.size() == 0) begin
                    nVec++; nErr++;
                    $display("[TB] FAIL out_valid_unexpected: dut %0d pulsed with 0x%0h, expected no pulse", d, outDataS[d]);
                end else begin
                    e = outQ.pop_front();
                    checkOutput("out_dut", d, int'(e.dut));
                    checkOutput("out_data", int'(outDataS[d]), int'(e.data));
                    checkOutput("out_cycle", int'(cyc), int'(e.cyc));
                end
            end
            if (rst_n && haltedS[d] && !prevHalted[d]) begin
                if (haltQ.size() == 0) begin
                    nVec++; nErr++;
                    $display("[TB] FAIL halt_unexpected: dut %0d halted at pc 0x%0h, expected running", d, pcS[d]);
                end else begin
                    e = haltQ.pop_front();
                    checkOutput("halt_dut", d, int'(e.dut));
                    checkOutput("halt_pc", int'(pcS[d]), int'(e.pc));
                    checkOutput("halt_acc", int'(accS[d]), int'(e.acc));
                    checkOutput("halt_busy", int'(busyS[d]), 0);
                    checkOutput("halt_cycle", int'(cyc), int'(e.cyc));
                end
            end
            prevHalted[d] = haltedS[d];
        end
    end

    task automatic checkResetState(input int d, input string tag);
        checkOutput({tag, "_address"}, int'(addrS[d]), 0);
        checkOutput({tag, "_out_data"}, int'(outDataS[d]), 0);
        checkOutput({tag, "_out_valid"}, int'(outValidS[d]), 0);
        checkOutput({tag, "_busy"}, int'(busyS[d]), 0);
        checkOutput({tag, "_halted"}, int'(haltedS[d]), 0);
        checkOutput({tag, "_pc"}, int'(pcS[d]), 0);
        checkOutput({tag, "_acc"}, int'(accS[d]), 0);
    endtask

    // Called just after a falling clock edge, so reset lands between edges.
    task automatic asyncReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkResetState(0, {tag, "A"});
        checkResetState(1, {tag, "B"});
        outQ.delete();
        haltQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput({tag, "_idle_busy"}, int'(busyS[0]) + int'(busyS[1]), 0);
            checkOutput({tag, "_idle_addr"}, int'(addrS[0]) + int'(addrS[1]), 0);
        end
    endtask

    // Runs the model, starts core d, queues expected results, then waits for
    // HALT or, for a non-halting run, stops after maxSteps instructions.
    task automatic applyStimulus(input int d, input int maxSteps, input string tag);
        int   len, s0, target;
        exp_t e;
        len = (d == 0) ? 16 : 256;
        if (!runModel(d, maxSteps)) begin
            nVec++; nErr++;
            $display("[TB] FAIL %s_image: program leaves the loaded image, expected a self-contained program", tag);
            return;
        end
        @(negedge clk);
        startS[d] = 1'b1;
        @(negedge clk);
        startS[d] = 1'b0;
        s0 = int'(cyc);
        checkOutput({tag, "_busy_on_start"}, int'(busyS[d]), 1);
        for (int i = 0; i < mOutData.size(); i++) begin
            e = '0;
            e.dut  = 1'(d);
            e.data = mOutData[i];
            e.cyc  = 32'(s0 + len + 2 + 2 * mOutStep[i]);
            outQ.push_back(e);
        end
        if (mHalted) begin
            e = '0;
            e.dut = 1'(d);
            e.pc  = 8'(mPc);
            e.acc = 8'(mAcc);
            e.cyc = 32'(s0 + len + 1 + 2 * mSteps);
            haltQ.push_back(e);
            for (int t = 0; t < len + 2 * mSteps + 8 && haltQ.size() != 0; t++) @(negedge clk);
            #1;
            if (haltQ.size() != 0) begin
                nVec++; nErr++;
                $display("[TB] FAIL %s_halt_timeout: halted=%0d, expected 1", tag, haltedS[d]);
                haltQ.delete();
            end
        end else begin
            target = s0 + len + 2 * maxSteps;
            while (int'(cyc) < target) @(negedge clk);
            #1;
            checkOutput({tag, "_pc"}, int'(pcS[d]), mPc);
            checkOutput({tag, "_acc"}, int'(accS[d]), mAcc);
            checkOutput({tag, "_busy"}, int'(busyS[d]), 1);
        end
        checkOutput({tag, "_pending_out"}, outQ.size(), 0);
        outQ.delete();
    endtask

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int s0, tries;
        bit ok;
        rst_n = 1'b1;
        startS[0] = 1'b0;
        startS[1] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            romA[i] = 8'h00;
            romB[i] = 8'h00;
        end

        #2 rst_n = 1'b0;
        #1;
        checkResetState(0, "por_A");
        checkResetState(1, "por_B");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_addr", int'(addrS[0]), 0);
            checkOutput("idle_busy", int'(busyS[0]), 0);
            checkOutput("idle_halted", int'(haltedS[0]), 0);
        end

        // Load sweep: address steps 0..15, then the first fetch one edge later.
        for (int i = 0; i < 256; i++) romA[i] = 8'(i + 16);
        @(negedge clk);
        startS[0] = 1'b1;
        @(negedge clk);
        startS[0] = 1'b0;
        s0 = int'(cyc);
        for (int j = 0; j < 16; j++) begin
            checkOutput($sformatf("load_addr%0d", j), int'(addrS[0]), j);
            checkOutput($sformatf("load_busy%0d", j), int'(busyS[0]), 1);
            @(negedge clk);
        end
        checkOutput("load_elapsed", int'(cyc) - s0, 16);
        checkOutput("load_addr_return", int'(addrS[0]), 0);
        for (int i = 0; i < 16; i++) checkOutput($sformatf("load_ram%0d", i), int'(dutA.r_ram[i]), i + 16);
        @(negedge clk);
        checkOutput("first_fetch_pc_held", int'(pcS[0]), 0);
        @(negedge clk);
        checkOutput("first_exec_pc_moved", int'(pcS[0] == 8'd1 || pcS[0] == 8'd2), 1);
        asyncReset("after_load");

        // acc=3 from the first instruction, then 7-3 without borrow.
        for (int i = 0; i < 256; i++) romA[i] = 8'h00;
        romA[0] = 8'd4; romA[1] = 8'd5; romA[2] = 8'hFF; romA[4] = 8'd3; romA[5] = 8'd7;
        applyStimulus(0, 50, "noborrow");
        checkOutput("noborrow_acc", int'(accS[0]), 4);
        checkOutput("noborrow_ram5", int'(dutA.r_ram[5]), 4);
        checkOutput("noborrow_pc", int'(pcS[0]), 2);

        // acc=5, then 2-5 borrows and skips word 2.
        for (int i = 0; i < 256; i++) romA[i] = 8'h00;
        romA[0] = 8'd4; romA[1] = 8'd6; romA[2] = 8'd0; romA[3] = 8'hFF; romA[4] = 8'd5; romA[6] = 8'd2;
        applyStimulus(0, 50, "borrow");
        checkOutput("borrow_acc", int'(accS[0]), 8'hFD);
        checkOutput("borrow_ram6", int'(dutA.r_ram[6]), 8'hFD);
        checkOutput("borrow_pc", int'(pcS[0]), 3);

        // Output write then halt, run twice to show a restart from HALT reloads.
        for (int i = 0; i < 256; i++) romA[i] = 8'h00;
        romA[0] = 8'd15; romA[1] = 8'hFF; romA[15] = 8'd9;
        for (int r = 0; r < 2; r++) begin
            applyStimulus(0, 50, $sformatf("output%0d", r));
            checkOutput("output_data", int'(outDataS[0]), 9);
            checkOutput("output_halted", int'(haltedS[0]), 1);
            checkOutput("output_busy", int'(busyS[0]), 0);
            checkOutput("output_pc", int'(pcS[0]), 1);
        end

        for (int n = 0; n < 30; n++) begin
            tries = 0;
            do begin
                for (int i = 0; i < 16; i++) romA[i] = randWord();
                ok = runModel(0, 40);
                tries++;
            end while (!ok && tries < 2000);
            if (!ok) continue;
            applyStimulus(0, 40, $sformatf("rand%0d", n));
            if (!mHalted) begin
                @(negedge clk);
                asyncReset($sformatf("rand%0d_rst", n));
            end
        end

        // All-zero image never borrows: pc runs 0..0xFF and wraps to 0x00.
        for (int i = 0; i < 256; i++) romB[i] = 8'h00;
        applyStimulus(1, 256, "wrap_nb");
        checkOutput("wrap_nb_pc", int'(pcS[1]), 0);
        checkOutput("wrap_nb_acc", int'(accS[1]), 0);
        @(negedge clk);
        asyncReset("wrap_nb_rst");

        // Instruction at 0xFE loads acc=5; the one at 0xFF computes 0-5 and skips to 0x01.
        romB[8'hFE] = 8'h10; romB[8'h10] = 8'd5; romB[8'hFF] = 8'h20;
        applyStimulus(1, 256, "wrap_b");
        checkOutput("wrap_b_pc", int'(pcS[1]), 1);
        checkOutput("wrap_b_acc", int'(accS[1]), 8'hFB);
        @(negedge clk);
        checkOutput("exec_before_reset_busy", int'(busyS[1]), 1);
        asyncReset("mid_exec");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
